// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine. Runs one SPARC memory op as
// one or two beats on a 32-bit req/gnt/rvalid bus, steers store lanes
// big-endian, returns load data right-justified and zero-extended to WB.
//
// Handshake: a beat's request (mem_req with addr/we/be/wdata) is held
// constant until the cycle mem_gnt is high; the response is the first
// mem_rvalid seen in a later cycle (an rvalid in the grant cycle is ignored).
// Upstream, MEM_stall=1 means EX must hold its inputs stable.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MEM_valid_in,
  input  logic [1:0]  MEM_op_in,
  input  logic [5:0]  MEM_op3_in,
  input  logic [31:0] MEM_addr_in,
  input  logic [63:0] MEM_store_data_in,
  output logic [63:0] MEM_load_data_out,
  output logic        MEM_done,
  output logic        MEM_stall,
  output logic        MEM_align_trap,
  output logic        MEM_bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_DBL  = 2'b11;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  // Last WAIT count before giving up: DONE then lands TIMEOUT_CYCLES
  // cycles after the grant cycle.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 2);

  state_t        state_q, state_d;
  logic [2:0]    op3_q, op3_d;
  logic [31:0]   addr_q, addr_d;
  logic [63:0]   data_q, data_d;
  logic          beat_q, beat_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   hi_q, hi_d;
  logic          trap_q, trap_d;
  logic          err_q, err_d;
  logic [63:0]   load_data_q, load_data_d;

  logic          accept;
  logic          misaligned;
  logic [1:0]    cur_size;
  logic          cur_store;
  logic [1:0]    off;
  logic [3:0]    be_c;
  logic [31:0]   wdata_c;
  logic [31:0]   extract_c;
  logic          op3_hi_unused;

  // Signed/unsigned variants differ only in WB, so the upper op3 bits are not needed here.
  assign op3_hi_unused = ^MEM_op3_in[5:3];

  assign accept    = MEM_valid_in && (MEM_op_in == 2'b11);
  assign cur_size  = op3_q[1:0];
  assign cur_store = op3_q[2];
  assign off       = addr_q[1:0];

  // Alignment check on the incoming op, by access size.
  always_comb begin
    misaligned = 1'b0;
    case (MEM_op3_in[1:0])
      SZ_HALF: misaligned = MEM_addr_in[0];
      SZ_WORD: misaligned = |MEM_addr_in[1:0];
      SZ_DBL:  misaligned = |MEM_addr_in[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Byte enables, store lane steering and load extraction for the current beat.
  always_comb begin
    be_c      = 4'b1111;
    wdata_c   = data_q[31:0];
    extract_c = mem_rdata;
    case (cur_size)
      SZ_BYTE: begin
        be_c    = 4'b1000 >> off;
        wdata_c = {4{data_q[7:0]}};
        case (off)
          2'd0:    extract_c = {24'd0, mem_rdata[31:24]};
          2'd1:    extract_c = {24'd0, mem_rdata[23:16]};
          2'd2:    extract_c = {24'd0, mem_rdata[15:8]};
          default: extract_c = {24'd0, mem_rdata[7:0]};
        endcase
      end
      SZ_HALF: begin
        be_c      = off[1] ? 4'b0011 : 4'b1100;
        wdata_c   = {2{data_q[15:0]}};
        extract_c = off[1] ? {16'd0, mem_rdata[15:0]} : {16'd0, mem_rdata[31:16]};
      end
      SZ_DBL: begin
        wdata_c = beat_q ? data_q[31:0] : data_q[63:32];
      end
      default: ;
    endcase
  end

  // Next-state and datapath updates for the IDLE/REQ/WAIT/DONE sequence.
  always_comb begin
    state_d     = state_q;
    op3_d       = op3_q;
    addr_d      = addr_q;
    data_d      = data_q;
    beat_d      = beat_q;
    tmo_d       = tmo_q;
    hi_d        = hi_q;
    trap_d      = trap_q;
    err_d       = err_q;
    load_data_d = load_data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op3_d  = MEM_op3_in[2:0];
          addr_d = MEM_addr_in;
          data_d = MEM_store_data_in;
          beat_d = 1'b0;
          tmo_d  = '0;
          hi_d   = '0;
          err_d  = 1'b0;
          if (misaligned) begin
            trap_d      = 1'b1;
            load_data_d = '0;
            state_d     = DONE;
          end else begin
            trap_d  = 1'b0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          tmo_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          if ((cur_size == SZ_DBL) && !beat_q) begin
            beat_d  = 1'b1;
            addr_d  = addr_q + 32'd4;
            hi_d    = mem_rdata;
            state_d = REQ;
          end else begin
            if (cur_store)              load_data_d = '0;
            else if (cur_size == SZ_DBL) load_data_d = {hi_q, mem_rdata};
            else                         load_data_d = {32'd0, extract_c};
            state_d = DONE;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d       = 1'b1;
          load_data_d = '0;
          state_d     = DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op3_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      beat_q      <= 1'b0;
      tmo_q       <= '0;
      hi_q        <= '0;
      trap_q      <= 1'b0;
      err_q       <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      op3_q       <= op3_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      beat_q      <= beat_d;
      tmo_q       <= tmo_d;
      hi_q        <= hi_d;
      trap_q      <= trap_d;
      err_q       <= err_d;
      load_data_q <= load_data_d;
    end
  end

  // Bus outputs are zero outside REQ so nothing stale leaks onto the bus.
  always_comb begin
    mem_req   = (state_q == REQ);
    mem_we    = mem_req && cur_store;
    mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
    mem_be    = mem_req ? be_c : 4'd0;
    mem_wdata = mem_req ? wdata_c : 32'd0;
  end

  // Pipeline-facing status.
  always_comb begin
    MEM_done          = (state_q == DONE);
    MEM_align_trap    = MEM_done && trap_q;
    MEM_bus_err       = MEM_done && err_q;
    MEM_stall         = (state_q == REQ) || (state_q == WAIT) || ((state_q == IDLE) && accept);
    MEM_load_data_out = load_data_q;
    dbg_state         = state_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: scenario tasks drive ops through a bus
// responder task and compare against a small reference model.
module tb_mem_access_unit;

  localparam logic [5:0] OP_LD   = 6'b000000;
  localparam logic [5:0] OP_LDUB = 6'b000001;
  localparam logic [5:0] OP_LDUH = 6'b000010;
  localparam logic [5:0] OP_LDD  = 6'b000011;
  localparam logic [5:0] OP_ST   = 6'b000100;
  localparam logic [5:0] OP_STB  = 6'b000101;
  localparam logic [5:0] OP_STH  = 6'b000110;
  localparam logic [5:0] OP_STD  = 6'b000111;
  localparam logic [5:0] OP_LDSB = 6'b001001;
  localparam logic [5:0] OP_LDSH = 6'b001010;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MEM_valid_in = 1'b0;
  logic [1:0]  MEM_op_in = 2'b00;
  logic [5:0]  MEM_op3_in = 6'd0;
  logic [31:0] MEM_addr_in = 32'd0;
  logic [63:0] MEM_store_data_in = 64'd0;
  logic [63:0] MEM_load_data_out;
  logic        MEM_done, MEM_stall, MEM_align_trap, MEM_bus_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail = 0;

  logic [63:0] exp_q[$];
  logic [31:0] rd_q[$];

  logic [31:0] obs_addr[$];
  logic [3:0]  obs_be[$];
  logic        obs_we[$];
  logic [31:0] obs_wd[$];
  int          obs_done_cyc[$];
  logic [63:0] obs_ld[$];
  logic        obs_trap[$];
  logic        obs_err[$];
  int          obs_req_cycles, obs_unstable, obs_gnt_cyc;
  logic [15:0] obs_stall;

  mem_access_unit #(.TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .reset(reset), .MEM_valid_in(MEM_valid_in), .MEM_op_in(MEM_op_in),
    .MEM_op3_in(MEM_op3_in), .MEM_addr_in(MEM_addr_in), .MEM_store_data_in(MEM_store_data_in),
    .MEM_load_data_out(MEM_load_data_out), .MEM_done(MEM_done), .MEM_stall(MEM_stall),
    .MEM_align_trap(MEM_align_trap), .MEM_bus_err(MEM_bus_err), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [3:0] m_be(input logic [5:0] op3, input logic [31:0] a);
    logic [3:0] r;
    r = 4'b1111;
    if (op3[1:0] == 2'b01) begin
      case (a[1:0])
        2'd0: r = 4'b1000;
        2'd1: r = 4'b0100;
        2'd2: r = 4'b0010;
        default: r = 4'b0001;
      endcase
    end else if (op3[1:0] == 2'b10) begin
      r = a[1] ? 4'b0011 : 4'b1100;
    end
    return r;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [5:0] op3, input logic [63:0] sd, input bit beat);
    logic [31:0] r;
    case (op3[1:0])
      2'b01:   r = {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
      2'b10:   r = {sd[15:0], sd[15:0]};
      2'b11:   r = beat ? sd[31:0] : sd[63:32];
      default: r = sd[31:0];
    endcase
    return r;
  endfunction

  function automatic logic [63:0] m_load(input logic [5:0] op3, input logic [31:0] a,
                                         input logic [31:0] rd0, input logic [31:0] rd1);
    logic [31:0] t;
    int o;
    o = int'(a[1:0]);
    if (op3[2]) return 64'd0;
    case (op3[1:0])
      2'b01: begin t = rd0 >> (8 * (3 - o)); return {56'd0, t[7:0]}; end
      2'b10: begin t = a[1] ? rd0 : (rd0 >> 16); return {48'd0, t[15:0]}; end
      2'b11: return {rd0, rd1};
      default: return {32'd0, rd0};
    endcase
  endfunction

  // ---------------- driver / bus responder ----------------
  // Relative cycle 0 is the accept cycle. Inputs are set at the falling
  // edge and outputs sampled 1 time unit later, well away from posedge.
  task automatic run_op(input logic [5:0] op3, input logic [31:0] addr, input logic [63:0] sdata,
                        input int hold, input int n_done, input int gnt_delay,
                        input bit rv_en, input bit early_rv);
    int wcnt;
    bit waiting_rv, first;
    logic [68:0] last_v;
    obs_addr.delete(); obs_be.delete(); obs_we.delete(); obs_wd.delete();
    obs_done_cyc.delete(); obs_ld.delete(); obs_trap.delete(); obs_err.delete();
    obs_req_cycles = 0; obs_unstable = 0; obs_gnt_cyc = -1; obs_stall = '0;
    wcnt = 0; waiting_rv = 0; first = 1; last_v = '0;
    for (int k = 0; k < 600 && obs_done_cyc.size() < n_done; k++) begin
      @(negedge clk);
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata = $urandom;
      MEM_valid_in = (k < hold);
      MEM_op_in = 2'b11;
      MEM_op3_in = op3;
      MEM_addr_in = addr;
      MEM_store_data_in = sdata;
      if (waiting_rv) begin
        if (rv_en) begin
          mem_rvalid = 1'b1;
          mem_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 32'd0;
        end
        waiting_rv = 0; first = 1; wcnt = 0;
      end else if (mem_req) begin
        if (first) begin
          obs_addr.push_back(mem_addr); obs_be.push_back(mem_be);
          obs_we.push_back(mem_we); obs_wd.push_back(mem_wdata);
          last_v = {mem_addr, mem_be, mem_we, mem_wdata};
          first = 0;
        end else if ({mem_addr, mem_be, mem_we, mem_wdata} !== last_v) begin
          obs_unstable++;
        end
        obs_req_cycles++;
        if (wcnt == gnt_delay) begin
          mem_gnt = 1'b1;
          obs_gnt_cyc = k;
          waiting_rv = 1;
          if (early_rv) begin mem_rvalid = 1'b1; mem_rdata = 32'h5A5A_5A5A; end
        end else begin
          wcnt++;
        end
      end
      #1;
      if (k < 16) obs_stall[k] = MEM_stall;
      if (MEM_done) begin
        obs_done_cyc.push_back(k); obs_ld.push_back(MEM_load_data_out);
        obs_trap.push_back(MEM_align_trap); obs_err.push_back(MEM_bus_err);
      end
    end
    MEM_valid_in = 1'b0; MEM_op_in = 2'b00;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== 69'd0) begin
      n_fail++; $display("FAIL reset_bus got req=%b we=%b addr=%h be=%b wd=%h exp all 0",
                         mem_req, mem_we, mem_addr, mem_be, mem_wdata);
    end
    n_checks++;
    if ({MEM_done, MEM_stall, MEM_align_trap, MEM_bus_err} !== 4'd0) begin
      n_fail++; $display("FAIL reset_status got=%b exp=0000", {MEM_done, MEM_stall, MEM_align_trap, MEM_bus_err});
    end
    n_checks++;
    if (MEM_load_data_out !== 64'd0) begin n_fail++; $display("FAIL reset_load got=%h exp=0", MEM_load_data_out); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ldub();
    logic [63:0] e;
    rd_q.push_back(32'hAABB_CCDD);
    exp_q.push_back(m_load(OP_LDUB, 32'h1001, 32'hAABB_CCDD, 32'd0));
    run_op(OP_LDUB, 32'h1001, 64'd0, 1, 1, 0, 1, 0);
    n_checks++;
    if (obs_done_cyc.size() != 1 || obs_done_cyc[0] != 3) begin
      n_fail++; $display("FAIL ldub_latency got n=%0d cyc=%0d exp cyc=3", obs_done_cyc.size(),
                         obs_done_cyc.size() ? obs_done_cyc[0] : -1);
    end
    n_checks++;
    if (obs_addr.size() != 1 || obs_addr[0] !== 32'h1000 || obs_be[0] !== 4'b0100 || obs_we[0] !== 1'b0) begin
      n_fail++; $display("FAIL ldub_bus got n=%0d addr=%h be=%b we=%b exp 1/00001000/0100/0",
                         obs_addr.size(), obs_addr.size() ? obs_addr[0] : 32'hx,
                         obs_be.size() ? obs_be[0] : 4'hx, obs_we.size() ? obs_we[0] : 1'bx);
    end
    e = exp_q.pop_front();
    n_checks++;
    if (obs_ld.size() == 0 || obs_ld[0] !== e) begin
      n_fail++; $display("FAIL ldub_data got=%h exp=%h", obs_ld.size() ? obs_ld[0] : 64'hx, e);
    end
  endtask

  task automatic test_sth();
    rd_q.push_back(32'h0);
    run_op(OP_STH, 32'h2002, 64'h0000_0000_0000_1234, 1, 1, 0, 1, 0);
    n_checks++;
    if (obs_addr.size() != 1 || obs_we[0] !== 1'b1 || obs_be[0] !== 4'b0011 || obs_wd[0] !== 32'h1234_1234) begin
      n_fail++; $display("FAIL sth_bus got n=%0d we=%b be=%b wd=%h exp 1/1/0011/12341234", obs_addr.size(),
                         obs_we.size() ? obs_we[0] : 1'bx, obs_be.size() ? obs_be[0] : 4'hx,
                         obs_wd.size() ? obs_wd[0] : 32'hx);
    end
    n_checks++;
    if (obs_stall[3:0] !== 4'b0111) begin n_fail++; $display("FAIL sth_stall got=%b exp=0111 (bit=cycle)", obs_stall[3:0]); end
    n_checks++;
    if (obs_done_cyc.size() != 1 || obs_done_cyc[0] != 3 || obs_ld[0] !== 64'd0) begin
      n_fail++; $display("FAIL sth_done got n=%0d cyc=%0d ld=%h exp cyc=3 ld=0", obs_done_cyc.size(),
                         obs_done_cyc.size() ? obs_done_cyc[0] : -1, obs_ld.size() ? obs_ld[0] : 64'hx);
    end
  endtask

  task automatic test_ldd();
    logic [63:0] e;
    rd_q.push_back(32'h1111_1111); rd_q.push_back(32'h2222_2222);
    exp_q.push_back(m_load(OP_LDD, 32'h3000, 32'h1111_1111, 32'h2222_2222));
    run_op(OP_LDD, 32'h3000, 64'd0, 1, 1, 0, 1, 0);
    n_checks++;
    if (obs_addr.size() != 2 || obs_addr[0] !== 32'h3000 || obs_addr[1] !== 32'h3004) begin
      n_fail++; $display("FAIL ldd_addrs got n=%0d a0=%h a1=%h exp 2/3000/3004", obs_addr.size(),
                         obs_addr.size() > 0 ? obs_addr[0] : 32'hx, obs_addr.size() > 1 ? obs_addr[1] : 32'hx);
    end
    n_checks++;
    if (obs_done_cyc.size() != 1 || obs_done_cyc[0] != 5) begin
      n_fail++; $display("FAIL ldd_latency got=%0d exp=5", obs_done_cyc.size() ? obs_done_cyc[0] : -1);
    end
    e = exp_q.pop_front();
    n_checks++;
    if (obs_ld.size() == 0 || obs_ld[0] !== e) begin
      n_fail++; $display("FAIL ldd_data got=%h exp=%h", obs_ld.size() ? obs_ld[0] : 64'hx, e);
    end
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (MEM_load_data_out !== e) begin n_fail++; $display("FAIL ldd_hold got=%h exp=%h", MEM_load_data_out, e); end
  endtask

  task automatic test_alignment();
    logic [5:0]  t_op[6]   = '{OP_LD, OP_LDUH, OP_STD, OP_LDSH, OP_STB, OP_LDD};
    logic [31:0] t_addr[6] = '{32'h4002, 32'h5001, 32'h6004, 32'h5002, 32'h5003, 32'h6008};
    bit          t_trap[6] = '{1, 1, 1, 0, 0, 0};
    logic [63:0] e;
    for (int i = 0; i < 6; i++) begin
      logic [31:0] r0, r1;
      int exp_cyc;
      r0 = $urandom; r1 = $urandom;
      if (!t_trap[i]) begin rd_q.push_back(r0); if (t_op[i][1:0] == 2'b11) rd_q.push_back(r1); end
      exp_q.push_back(t_trap[i] ? 64'd0 : m_load(t_op[i], t_addr[i], r0, r1));
      exp_cyc = t_trap[i] ? 1 : ((t_op[i][1:0] == 2'b11) ? 5 : 3);
      run_op(t_op[i], t_addr[i], {$urandom, $urandom}, 1, 1, 0, 1, 0);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_done_cyc.size() != 1 || obs_done_cyc[0] != exp_cyc || obs_trap[0] !== t_trap[i] ||
          obs_err[0] !== 1'b0 || obs_ld[0] !== e) begin
        n_fail++; $display("FAIL align_%0d got cyc=%0d trap=%b ld=%h exp cyc=%0d trap=%b ld=%h", i,
                           obs_done_cyc.size() ? obs_done_cyc[0] : -1, obs_trap.size() ? obs_trap[0] : 1'bx,
                           obs_ld.size() ? obs_ld[0] : 64'hx, exp_cyc, t_trap[i], e);
      end
      if (t_trap[i]) begin
        n_checks++;
        if (obs_req_cycles != 0 || obs_stall[1:0] !== 2'b01) begin
          n_fail++; $display("FAIL align_trap_bus_%0d got req_cycles=%0d stall=%b exp 0/01", i, obs_req_cycles, obs_stall[1:0]);
        end
      end
    end
  endtask

  task automatic test_lanes();
    logic [5:0] ops[8] = '{OP_LDUB, OP_LDSB, OP_STB, OP_LDUH, OP_LDSH, OP_STH, OP_LD, OP_ST};
    for (int i = 0; i < 12; i++) begin
      logic [5:0] op3;
      logic [31:0] a, rd;
      logic [63:0] sd, e;
      int gd;
      op3 = ops[$urandom_range(0, 7)];
      a = $urandom;
      if (op3[1:0] == 2'b10) a[0] = 1'b0;
      if (op3[1:0] == 2'b00) a[1:0] = 2'b00;
      rd = $urandom; sd = {$urandom, $urandom};
      gd = $urandom_range(0, 2);
      rd_q.push_back(rd);
      exp_q.push_back(m_load(op3, a, rd, 32'd0));
      run_op(op3, a, sd, 1, 1, gd, 1, 0);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_addr.size() != 1 || obs_addr[0] !== {a[31:2], 2'b00} || obs_be[0] !== m_be(op3, a) ||
          obs_we[0] !== op3[2] || (op3[2] && obs_wd[0] !== m_wdata(op3, sd, 0))) begin
        n_fail++; $display("FAIL lanes_bus_%0d op3=%b a=%h got addr=%h be=%b we=%b wd=%h exp be=%b wd=%h",
                           i, op3, a, obs_addr.size() ? obs_addr[0] : 32'hx, obs_be.size() ? obs_be[0] : 4'hx,
                           obs_we.size() ? obs_we[0] : 1'bx, obs_wd.size() ? obs_wd[0] : 32'hx,
                           m_be(op3, a), m_wdata(op3, sd, 0));
      end
      n_checks++;
      if (obs_done_cyc.size() != 1 || obs_done_cyc[0] != 3 + gd || obs_ld[0] !== e) begin
        n_fail++; $display("FAIL lanes_data_%0d got cyc=%0d ld=%h exp cyc=%0d ld=%h", i,
                           obs_done_cyc.size() ? obs_done_cyc[0] : -1, obs_ld.size() ? obs_ld[0] : 64'hx, 3 + gd, e);
      end
    end
  endtask

  task automatic test_std();
    rd_q.push_back(32'd0); rd_q.push_back(32'd0);
    run_op(OP_STD, 32'h9010, 64'hCAFE_F00D_0123_4567, 1, 1, 1, 1, 0);
    n_checks++;
    if (obs_wd.size() != 2 || obs_wd[0] !== 32'hCAFE_F00D || obs_wd[1] !== 32'h0123_4567 ||
        obs_addr[1] !== 32'h9014 || obs_ld[0] !== 64'd0) begin
      n_fail++; $display("FAIL std_beats got n=%0d wd0=%h wd1=%h exp 2/cafef00d/01234567",
                         obs_wd.size(), obs_wd.size() > 0 ? obs_wd[0] : 32'hx, obs_wd.size() > 1 ? obs_wd[1] : 32'hx);
    end
  endtask

  task automatic test_gnt_rvalid_same();
    logic [63:0] e;
    rd_q.push_back(32'h0BAD_F00D);
    exp_q.push_back(64'h0000_0000_0BAD_F00D);
    run_op(OP_LD, 32'h8000, 64'd0, 1, 1, 0, 1, 1);
    e = exp_q.pop_front();
    n_checks++;
    if (obs_done_cyc.size() != 1 || obs_done_cyc[0] != 3 || obs_ld[0] !== e) begin
      n_fail++; $display("FAIL gnt_rvalid_same got cyc=%0d ld=%h exp cyc=3 ld=%h",
                         obs_done_cyc.size() ? obs_done_cyc[0] : -1, obs_ld.size() ? obs_ld[0] : 64'hx, e);
    end
  endtask

  task automatic test_timeout();
    run_op(OP_LD, 32'h4000, 64'd0, 1, 1, 3, 0, 0);
    n_checks++;
    if (obs_req_cycles != 4 || obs_unstable != 0 || obs_gnt_cyc != 4) begin
      n_fail++; $display("FAIL timeout_req got cycles=%0d unstable=%0d gnt=%0d exp 4/0/4",
                         obs_req_cycles, obs_unstable, obs_gnt_cyc);
    end
    n_checks++;
    if (obs_done_cyc.size() != 1 || obs_done_cyc[0] - obs_gnt_cyc != 255) begin
      n_fail++; $display("FAIL timeout_latency got n=%0d delta=%0d exp 255", obs_done_cyc.size(),
                         obs_done_cyc.size() ? obs_done_cyc[0] - obs_gnt_cyc : -1);
    end
    n_checks++;
    if (obs_err.size() == 0 || obs_err[0] !== 1'b1 || obs_trap[0] !== 1'b0 || obs_ld[0] !== 64'd0) begin
      n_fail++; $display("FAIL timeout_flags got err=%b trap=%b ld=%h exp 1/0/0",
                         obs_err.size() ? obs_err[0] : 1'bx, obs_trap.size() ? obs_trap[0] : 1'bx,
                         obs_ld.size() ? obs_ld[0] : 64'hx);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] e0, e1;
    rd_q.push_back(32'h1357_9BDF); rd_q.push_back(32'h2468_ACE0);
    exp_q.push_back(64'h0000_0000_1357_9BDF); exp_q.push_back(64'h0000_0000_2468_ACE0);
    run_op(OP_LD, 32'hA000, 64'd0, 5, 2, 0, 1, 0);
    e0 = exp_q.pop_front(); e1 = exp_q.pop_front();
    n_checks++;
    if (obs_done_cyc.size() != 2 || obs_done_cyc[0] != 3 || obs_done_cyc[1] != 7) begin
      n_fail++; $display("FAIL b2b_spacing got n=%0d c0=%0d c1=%0d exp 2/3/7", obs_done_cyc.size(),
                         obs_done_cyc.size() > 0 ? obs_done_cyc[0] : -1, obs_done_cyc.size() > 1 ? obs_done_cyc[1] : -1);
    end
    n_checks++;
    if (obs_ld.size() != 2 || obs_ld[0] !== e0 || obs_ld[1] !== e1) begin
      n_fail++; $display("FAIL b2b_data got n=%0d d0=%h d1=%h exp %h %h", obs_ld.size(),
                         obs_ld.size() > 0 ? obs_ld[0] : 64'hx, obs_ld.size() > 1 ? obs_ld[1] : 64'hx, e0, e1);
    end
  endtask

  task automatic test_reset_mid();
    int seen_done;
    logic [63:0] e;
    seen_done = 0;
    @(negedge clk);
    MEM_valid_in = 1'b1; MEM_op_in = 2'b11; MEM_op3_in = OP_STD;
    MEM_addr_in = 32'h7000; MEM_store_data_in = 64'h0102_0304_0506_0708;
    @(negedge clk);
    MEM_valid_in = 1'b0;
    mem_gnt = mem_req;
    #1;
    n_checks++;
    if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_req got=%b exp=1", mem_req); end
    @(negedge clk);
    mem_gnt = 1'b0;
    reset = 1'b1;
    #1;
    n_checks++;
    if (dbg_state !== 2'd2) begin n_fail++; $display("FAIL rstmid_wait got=%0d exp=2", dbg_state); end
    @(negedge clk);
    reset = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    #1;
    if (MEM_done) seen_done++;
    n_checks++;
    if ({mem_req, MEM_stall, dbg_state} !== 4'd0 || MEM_load_data_out !== 64'd0) begin
      n_fail++; $display("FAIL rstmid_idle got req=%b stall=%b st=%0d ld=%h exp 0/0/0/0",
                         mem_req, MEM_stall, dbg_state, MEM_load_data_out);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      #1;
      if (MEM_done || mem_req) seen_done++;
    end
    n_checks++;
    if (seen_done != 0 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL rstmid_quiet got done_or_req=%0d st=%0d exp 0/0", seen_done, dbg_state);
    end
    rd_q.push_back(32'h0000_BEEF);
    exp_q.push_back(64'h0000_0000_0000_BEEF);
    run_op(OP_LD, 32'h7100, 64'd0, 1, 1, 0, 1, 0);
    e = exp_q.pop_front();
    n_checks++;
    if (obs_done_cyc.size() != 1 || obs_done_cyc[0] != 3 || obs_ld[0] !== e) begin
      n_fail++; $display("FAIL rstmid_recover got cyc=%0d ld=%h exp cyc=3 ld=%h",
                         obs_done_cyc.size() ? obs_done_cyc[0] : -1, obs_ld.size() ? obs_ld[0] : 64'hx, e);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_ldub();
    test_sth();
    test_ldd();
    test_alignment();
    test_lanes();
    test_std();
    test_gnt_rvalid_same();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
